// File: rtl/fifo_rd_fwft_if.sv
// FIFO read-port and FWFT stream signals of the read-side adapter.
interface fifo_rd_fwft_if #(
  parameter int DATA_WIDTH = 32
);
  // FIFO read port
  logic                  r_empty;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_pop;
  // FWFT output stream
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_ready;
  logic [1:0]            o_level;

  // Adapter side
  modport slave (
    input  r_empty, r_data, o_ready,
    output r_pop, o_valid, o_data, o_level
  );

  // FIFO + stream consumer side
  modport master (
    output r_empty, r_data, o_ready,
    input  r_pop, o_valid, o_data, o_level
  );
endinterface

// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through adapter for a pop/empty FIFO read port.
// A 2-entry registered queue (head/tail) absorbs the one-cycle read
// latency so the stream runs at 1 word/cycle under continuous ready.
module fifo_rd_fwft #(
  parameter int DATA_WIDTH = 32
) (
  input  logic           r_clk,
  input  logic           rst,
  fifo_rd_fwft_if.slave  bus
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_count;
  logic                  r_valid;
  logic                  r_in_flight;

  logic                  w_deq;
  logic                  w_arrive;
  logic                  w_pop;
  logic [2:0]            w_room;
  logic [2:0]            w_cnt_nxt;

  // Occupancy math in 3 bits so count + in_flight - deq never wraps.
  always_comb begin
    w_deq     = r_valid && bus.o_ready;
    w_arrive  = r_in_flight;
    w_room    = {1'b0, r_count} + {2'b00, r_in_flight} - {2'b00, w_deq};
    w_cnt_nxt = {1'b0, r_count} + {2'b00, w_arrive} - {2'b00, w_deq};
    w_pop     = !rst && !bus.r_empty && (w_room < 3'd2);
  end

  assign bus.r_pop   = w_pop;
  assign bus.o_valid = r_valid;
  assign bus.o_data  = r_head;
  assign bus.o_level = r_count;

  // Queue update; a pop always has a slot waiting when its data returns.
  always_ff @(posedge r_clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= 2'd0;
      r_valid     <= 1'b0;
      r_in_flight <= 1'b0;
    end else begin
      r_in_flight <= w_pop;
      r_count     <= w_cnt_nxt[1:0];
      r_valid     <= (w_cnt_nxt != 3'd0);
      case ({w_deq, w_arrive})
        2'b10: r_head <= r_tail;
        2'b01: begin
          if (r_count == 2'd0) r_head <= bus.r_data;
          else                 r_tail <= bus.r_data;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= bus.r_data;
          end else begin
            r_head <= r_tail;
            r_tail <= bus.r_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Directed bench for fifo_rd_fwft with a behavioural FIFO read port.
module tb_fifo_rd_fwft;
  localparam int DW = 32;

  logic r_clk = 1'b0;
  logic rst;
  always #5 r_clk = ~r_clk;

  fifo_rd_fwft_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_fwft #(.DATA_WIDTH(DW)) dut (
    .r_clk (r_clk),
    .rst   (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  int n_deq = 0;
  logic [DW-1:0] q[$];    // FIFO contents
  logic [DW-1:0] exp[$];  // expected stream order
  logic mask_en = 1'b0;
  logic mask    = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge r_clk); #2;
  endtask

  task automatic push(input logic [DW-1:0] w);
    q.push_back(w);
    exp.push_back(w);
  endtask

  // FIFO model: pop seen in cycle N returns data during cycle N+1
  initial begin
    logic v;
    logic [DW-1:0] w;
    bus.r_empty = 1'b1;
    bus.r_data  = 32'hDEADBEEF;
    forever begin
      @(negedge r_clk);
      v = bus.r_pop;
      w = 32'hDEADBEEF;
      if (v) begin
        if (q.size() == 0) chk("pop_underflow", 1, 0);
        else w = q.pop_front();
      end
      @(posedge r_clk); #1;
      mask = mask_en ? ~mask : 1'b0;
      bus.r_data  = v ? w : 32'hDEADBEEF;
      bus.r_empty = (q.size() == 0) || mask;
    end
  end

  // Scoreboard and invariants, sampled mid-cycle
  initial begin
    forever begin
      @(negedge r_clk);
      if (!rst) begin
        chk("pop_while_empty", {31'd0, bus.r_pop && bus.r_empty}, 0);
        chk("level_max", {31'd0, bus.o_level == 2'd3}, 0);
      end
      if (bus.r_pop) n_pop++;
      if (bus.o_valid && bus.o_ready) begin
        n_deq++;
        if (exp.size() == 0) chk("sb_extra", 1, 0);
        else chk("sb_data", bus.o_data, exp.pop_front());
      end
    end
  end

  initial begin
    logic [DW-1:0] w1 [4];
    logic          pv [8];
    logic          vv [8];
    logic [DW-1:0] dv [8];
    logic [1:0]    lv [8];
    int base, cyc, vcnt, run, maxrun, lmax;

    rst = 1'b1;
    bus.o_ready = 1'b0;
    repeat (3) step();
    @(negedge r_clk);
    chk("rst_pop", {31'd0, bus.r_pop}, 0);
    step();
    rst = 1'b0;
    @(negedge r_clk);
    chk("rst_valid", {31'd0, bus.o_valid}, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_level", {30'd0, bus.o_level}, 0);

    // 1: four words, continuous ready
    w1[0] = 32'h11; w1[1] = 32'h22; w1[2] = 32'h33; w1[3] = 32'h44;
    step();
    bus.o_ready = 1'b1;
    for (int k = 0; k < 4; k++) push(w1[k]);
    cyc = 0;
    do begin
      @(negedge r_clk);
      cyc++;
    end while (!bus.r_pop && cyc < 10);
    chk("t1_first_pop", {31'd0, bus.r_pop}, 1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge r_clk);
      pv[i] = bus.r_pop; vv[i] = bus.o_valid; dv[i] = bus.o_data; lv[i] = bus.o_level;
    end
    lmax = 0;
    for (int i = 0; i < 8; i++) if (int'(lv[i]) > lmax) lmax = int'(lv[i]);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_pop%0d", k), {31'd0, pv[k]}, 1);
      chk($sformatf("t1_valid%0d", k), {31'd0, vv[k+2]}, 1);
      chk($sformatf("t1_data%0d", k), dv[k+2], w1[k]);
    end
    chk("t1_pop_end", {31'd0, pv[4]}, 0);
    chk("t1_valid_early", {31'd0, vv[1]}, 0);
    chk("t1_valid_end", {31'd0, vv[6]}, 0);
    chk("t1_level_max", lmax, 1);

    // 2: backpressure with 8 words
    step();
    bus.o_ready = 1'b0;
    base = n_pop;
    for (int k = 0; k < 8; k++) push(32'hA0 + k);
    repeat (8) step();
    @(negedge r_clk);
    chk("t2_pops", n_pop - base, 2);
    chk("t2_level", {30'd0, bus.o_level}, 2);
    chk("t2_rpop", {31'd0, bus.r_pop}, 0);
    chk("t2_head", bus.o_data, 32'hA0);
    step();
    chk("t2_hold", bus.o_data, 32'hA0);
    bus.o_ready = 1'b1;
    cyc = 0;
    while (exp.size() != 0 && cyc < 40) begin
      @(negedge r_clk); #1;
      cyc++;
    end
    chk("t2_drained", exp.size(), 0);
    chk("t2_rate", {31'd0, cyc <= 9}, 1);

    // 3: random ready, 1000 words
    step();
    for (int k = 0; k < 1000; k++) push($urandom());
    cyc = 0;
    while (exp.size() != 0 && cyc < 6000) begin
      bus.o_ready = $urandom_range(0, 1);
      step();
      cyc++;
    end
    chk("t3_drained", exp.size(), 0);

    // 4: empty toggling every cycle
    bus.o_ready = 1'b1;
    repeat (4) step();
    mask_en = 1'b1;
    base = n_deq;
    for (int k = 0; k < 10; k++) push(32'hC0 + k);
    vcnt = 0; run = 0; maxrun = 0; cyc = 0;
    while ((exp.size() != 0 || bus.o_valid) && cyc < 80) begin
      @(negedge r_clk); #1;
      cyc++;
      if (bus.o_valid) begin vcnt++; run++; end else run = 0;
      if (run > maxrun) maxrun = run;
    end
    mask_en = 1'b0;
    chk("t4_drained", exp.size(), 0);
    chk("t4_delivered", n_deq - base, 10);
    chk("t4_valid_cycles", vcnt, 10);
    chk("t4_gap", maxrun, 1);

    // 5: reset mid-stream with a word in flight
    step();
    for (int k = 0; k < 20; k++) push(32'hE0 + k);
    repeat (6) step();
    @(negedge r_clk);
    chk("t5_pre_pop", {31'd0, bus.r_pop}, 1);
    chk("t5_pre_level", {30'd0, bus.o_level}, 1);
    step();
    rst = 1'b1;
    @(negedge r_clk);
    chk("t5_rst_pop", {31'd0, bus.r_pop}, 0);
    #1;
    q.delete();
    exp.delete();
    step();
    rst = 1'b0;
    bus.o_ready = 1'b0;
    @(negedge r_clk);
    chk("t5_valid", {31'd0, bus.o_valid}, 0);
    chk("t5_level", {30'd0, bus.o_level}, 0);
    repeat (3) step();
    @(negedge r_clk);
    chk("t5_no_ghost", {31'd0, bus.o_valid}, 0);

    // 6: single word
    step();
    bus.o_ready = 1'b1;
    base = n_pop;
    push(32'h5A5A);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge r_clk);
      if (bus.o_valid) vcnt++;
    end
    chk("t6_valid_cycles", vcnt, 1);
    chk("t6_pops", n_pop - base, 1);
    chk("t6_level", {30'd0, bus.o_level}, 0);
    chk("t6_drained", exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
